// File: rtl/lr35902_joypad_pkg.sv
// Shared constants for the joypad block: button bit positions and default debounce depth.
// Button indices follow the btn_n / buttons_n bit order.
package lr35902_joypad_pkg;

    localparam int unsigned BTN_RIGHT  = 0;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_UP     = 2;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_A      = 4;
    localparam int unsigned BTN_B      = 5;
    localparam int unsigned BTN_SELECT = 6;
    localparam int unsigned BTN_START  = 7;

    localparam int unsigned NUM_BTNS                = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/lr35902_debounce.sv
// Single-button two-flop synchronizer plus saturating debounce counter.
// Latency: a raw edge captured at E0 reaches stable_o after edge E0+1+DEBOUNCE_CYCLES; no backpressure.
module lr35902_debounce
    import lr35902_joypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic stable_o
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with stable restarts the count, so glitches never accumulate.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/lr35902_joypad.sv
// Game Boy joypad: per-button debounce, P14/P15 matrix column mux and press pulse.
// Latency: columns and press are registered one cycle after the debounced state; no backpressure.
module lr35902_joypad
    import lr35902_joypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] btn_n,
    input  logic       p14,
    input  logic       p15,
    output logic       p10,
    output logic       p11,
    output logic       p12,
    output logic       p13,
    output logic [7:0] buttons_n,
    output logic       press
);

    logic [7:0] stable;
    logic [7:0] stable_prev_q;
    logic [3:0] dir;
    logic [3:0] act;
    logic [3:0] col_q;
    logic [3:0] col_d;
    logic       press_q;
    logic       press_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        lr35902_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .btn_n_i (btn_n[i]),
            .stable_o(stable[i])
        );
    end

    always_comb begin
        dir     = p14 ? 4'hF : {stable[BTN_DOWN], stable[BTN_UP], stable[BTN_LEFT], stable[BTN_RIGHT]};
        act     = p15 ? 4'hF : {stable[BTN_START], stable[BTN_SELECT], stable[BTN_B], stable[BTN_A]};
        col_d   = dir & act;
        // OR across bits merges simultaneous presses into one pulse.
        press_d = |(stable_prev_q & ~stable);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev_q <= 8'hFF;
            col_q         <= 4'hF;
            press_q       <= 1'b0;
        end else begin
            stable_prev_q <= stable;
            col_q         <= col_d;
            press_q       <= press_d;
        end
    end

    assign buttons_n = stable;
    assign {p13, p12, p11, p10} = col_q;
    assign press = press_q;

endmodule
